regfile_writeback: RTL and testbench

Write-side arbiter for the 32x32 register bank. It merges results from two producers into the bank's single write port (`addr_d`, `data`, `write`): the ALU, which has priority, and the memory/load unit. Memory results that lose arbitration go into a small ordered queue. The block also tracks queued destinations so decode can stall on pending loads.

---
 rtl/regfile_writeback_if.sv | 36 +++
 rtl/regfile_writeback.sv | 81 ++++++++
 tb/tb_regfile_writeback.sv | 118 +++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/memory result inputs, bank write port and decode busy checks (WB_BYPASS_EN adds bank_a/b, rd_a/b)
interface regfile_writeback_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data;
  logic              write;
  logic [ADDR_W-1:0] chk_addr_a;
  logic [ADDR_W-1:0] chk_addr_b;
  logic              busy_a;
  logic              busy_b;
`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] bank_a;
  logic [DATA_W-1:0] bank_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  modport master (output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
                  chk_addr_a, chk_addr_b, bank_a, bank_b,
                  input mem_ready, addr_d, data, write, busy_a, busy_b, rd_a, rd_b);
  modport slave (input alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
                 chk_addr_a, chk_addr_b, bank_a, bank_b,
                 output mem_ready, addr_d, data, write, busy_a, busy_b, rd_a, rd_b);
`else
  modport master (output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
                  chk_addr_a, chk_addr_b,
                  input mem_ready, addr_d, data, write, busy_a, busy_b);
  modport slave (input alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
                 chk_addr_a, chk_addr_b,
                 output mem_ready, addr_d, data, write, busy_a, busy_b);
`endif
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: ALU-priority merge of ALU and memory results into one bank write port, with kill-aware memory queue and busy tracking (ports: clk, reset, bus; optional WB_BYPASS_EN)
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic reset,
  regfile_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_live;
  logic [PW-1:0]     rptr, wptr;
  logic [PW:0]       count;
  logic xfer, empty, head_live, pop, bypass, push, sel_head, wr, busy_a, busy_b;
  assign bus.mem_ready = count != (PW+1)'(DEPTH);
  assign xfer      = bus.mem_valid && bus.mem_ready;
  assign empty     = count == '0;
  assign head_live = !empty && q_live[rptr];
  // a dead head leaves regardless of the ALU; a live head leaves only when written
  assign pop       = !empty && (!q_live[rptr] || !bus.alu_valid);
  assign sel_head  = !bus.alu_valid && head_live;
  assign bypass    = !bus.alu_valid && empty && xfer;
  // a memory result to the ALU's destination in the same cycle is older, so it is dropped
  assign push      = xfer && !bypass && !(bus.alu_valid && bus.mem_addr == bus.alu_addr);
  assign wr        = bus.alu_valid || head_live || bypass;
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wptr] <= bus.mem_addr;
      q_data[wptr] <= bus.mem_data;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      q_live     <= '0;
      bus.write  <= 1'b0;
      bus.addr_d <= '0;
      bus.data   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (bus.alu_valid && q_addr[i] == bus.alu_addr) q_live[i] <= 1'b0;
      if (pop) begin
        q_live[rptr] <= 1'b0;
        rptr         <= rptr + 1'b1;
      end
      if (push) begin
        q_live[wptr] <= 1'b1;
        wptr         <= wptr + 1'b1;
      end
      count     <= count + (PW+1)'(push) - (PW+1)'(pop);
      bus.write <= wr;
      if (wr) begin
        bus.addr_d <= bus.alu_valid ? bus.alu_addr : sel_head ? q_addr[rptr] : bus.mem_addr;
        bus.data   <= bus.alu_valid ? bus.alu_data : sel_head ? q_data[rptr] : bus.mem_data;
      end
    end
  end
  always_comb begin
`ifdef WB_BYPASS_EN
    busy_a = 1'b0;
    busy_b = 1'b0;
`else
    busy_a = bus.write && bus.addr_d == bus.chk_addr_a;
    busy_b = bus.write && bus.addr_d == bus.chk_addr_b;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      busy_a = busy_a || (q_live[i] && q_addr[i] == bus.chk_addr_a);
      busy_b = busy_b || (q_live[i] && q_addr[i] == bus.chk_addr_b);
    end
  end
  assign bus.busy_a = busy_a;
  assign bus.busy_b = busy_b;
`ifdef WB_BYPASS_EN
  assign bus.rd_a = (bus.write && bus.addr_d == bus.chk_addr_a) ? bus.data : bus.bank_a;
  assign bus.rd_b = (bus.write && bus.addr_d == bus.chk_addr_b) ? bus.data : bus.bank_b;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed and random stimulus checked against a queue-based reference model
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_err = 0;
  ent_t q[$];
  bit e_wr = 0;
  logic [4:0] e_ad = '0;
  logic [31:0] e_dt = '0;
  regfile_writeback_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit busy_of(input logic [4:0] c);
    bit b = 0;
`ifndef WB_BYPASS_EN
    b = e_wr && e_ad == c;
`endif
    foreach (q[i]) if (q[i].live && q[i].a == c) b = 1;
    return b;
  endfunction
  // called just after a falling edge; returns at the next falling edge
  task automatic step(input bit rs, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] ca, input logic [4:0] cb);
    bit xfer, hd, hl, byp, nw;
    reset = rs;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.chk_addr_a = ca; bus.chk_addr_b = cb;
`ifdef WB_BYPASS_EN
    bus.bank_a = $urandom; bus.bank_b = $urandom;
`endif
    #1;
    chk("write", bus.write, e_wr);
    chk("addr_d", bus.addr_d, e_ad);
    chk("data", bus.data, e_dt);
    chk("mem_ready", bus.mem_ready, q.size() != DEPTH);
    chk("busy_a", bus.busy_a, busy_of(ca));
    chk("busy_b", bus.busy_b, busy_of(cb));
`ifdef WB_BYPASS_EN
    chk("rd_a", bus.rd_a, (e_wr && e_ad == ca) ? e_dt : bus.bank_a);
    chk("rd_b", bus.rd_b, (e_wr && e_ad == cb) ? e_dt : bus.bank_b);
`endif
    if (rs) begin
      q.delete();
      e_wr = 0; e_ad = '0; e_dt = '0;
    end else begin
      xfer = mv && q.size() != DEPTH;
      hd = q.size() > 0 && !q[0].live;
      hl = q.size() > 0 && q[0].live;
      byp = 0;
      nw = 1;
      if (av) begin
        e_ad = aa; e_dt = ad;
        foreach (q[i]) if (q[i].a == aa) q[i].live = 0;
        if (hd) void'(q.pop_front());
      end else if (hl) begin
        e_ad = q[0].a; e_dt = q[0].d;
        void'(q.pop_front());
      end else if (q.size() == 0 && xfer) begin
        e_ad = ma; e_dt = md; byp = 1;
      end else begin
        nw = 0;
        if (hd) void'(q.pop_front());
      end
      if (xfer && !byp && !(av && ma == aa)) q.push_back('{a: ma, d: md, live: 1});
      e_wr = nw;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic [4:0] ca, input logic [4:0] cb);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ca, cb);
  endtask
  initial begin
    bus.alu_valid = 1; bus.alu_addr = 5'd9; bus.alu_data = 32'h1;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.chk_addr_a = '0; bus.chk_addr_b = '0;
`ifdef WB_BYPASS_EN
    bus.bank_a = '0; bus.bank_b = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1, 1, 5'd1, 32'h2, 1, 5'd2, 32'h3, 5'd1, 5'd2);
    idle(1, 5'd1, 5'd2);
    step(0, 1, 5'd1, 32'h2, 0, 0, 0, 5'd1, 5'd0);
    idle(2, 5'd1, 5'd0);
    step(0, 1, 5'd3, 32'h5, 1, 5'd4, 32'h7, 5'd3, 5'd4);
    idle(3, 5'd3, 5'd4);
    step(0, 1, 5'd1, 32'h11, 1, 5'd6, 32'h9, 5'd6, 5'd1);
    step(0, 1, 5'd2, 32'h12, 0, 0, 0, 5'd6, 5'd2);
    step(0, 1, 5'd6, 32'hA, 0, 0, 0, 5'd6, 5'd2);
    idle(3, 5'd6, 5'd2);
    for (int i = 0; i <= DEPTH; i++)
      step(0, 1, 5'(10 + i), 32'h100 + i, 1, 5'(20 + i), 32'h200 + i, 5'(20 + i), 5'd20);
    idle(DEPTH + 2, 5'd21, 5'd23);
    step(1, 1, 5'd7, 32'h7, 1, 5'd8, 32'h8, 5'd7, 5'd8);
    idle(1, 5'd7, 5'd8);
    for (int seg = 0; seg < 40; seg++) begin
      int ap = (seg % 2) ? 90 : 35;
      for (int i = 0; i < 50; i++)
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < ap, 5'($urandom_range(0, 5)), $urandom,
             $urandom_range(0, 99) < 60, 5'($urandom_range(0, 5)), $urandom,
             5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
    end
    idle(DEPTH + 2, 5'd0, 5'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
